// File: rtl/bsg_reset_release_sequencer_if.sv
// Control bundle between the reset sequencer and the domains it releases:
// software reset request, per-stage ready acknowledgements, per-stage resets and done.
interface bsg_reset_release_sequencer_if #(
    parameter int num_stages_p = 3
);
    logic                    sw_reset_i;
    logic [num_stages_p-1:0] stage_ready_i;
    logic [num_stages_p-1:0] reset_o;
    logic                    done_o;

    modport master (
        output sw_reset_i,
        output stage_ready_i,
        input  reset_o,
        input  done_o
    );

    modport slave (
        input  sw_reset_i,
        input  stage_ready_i,
        output reset_o,
        output done_o
    );
endinterface

// File: rtl/bsg_reset_release_sequencer.sv
// Asserts all downstream resets asynchronously and releases them one stage at a time
// after a synchronized deassertion, spacing stages by a hold count and a ready handshake.
module bsg_reset_release_sequencer #(
    parameter int num_stages_p  = 3,
    parameter int sync_depth_p  = 2,
    parameter int hold_cycles_p = 16
) (
    input logic                          clk_i,
    input logic                          async_reset_i,
    bsg_reset_release_sequencer_if.slave ctrl
);
    localparam int cnt_w_lp = (hold_cycles_p > 1) ? $clog2(hold_cycles_p) : 1;
    localparam int idx_w_lp = (num_stages_p > 1) ? $clog2(num_stages_p) : 1;
    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(hold_cycles_p - 1);
    localparam logic [idx_w_lp-1:0] idx_last_lp = idx_w_lp'(num_stages_p - 1);

    typedef enum logic [1:0] {
        HOLD_S = 2'd0,
        WAIT_S = 2'd1,
        DONE_S = 2'd2
    } state_e;

    logic [sync_depth_p-1:0] sync_r;
    logic                    rst_seq_s;
    state_e                  state_r, state_n_s;
    logic [cnt_w_lp-1:0]     cnt_r, cnt_n_s;
    logic [idx_w_lp-1:0]     idx_r, idx_n_s;
    logic [num_stages_p-1:0] reset_r, reset_n_s;
    logic                    done_r, done_n_s;

    // Deassertion synchronizer: set at once by the pin, drains to 0 one flop per edge.
    always_ff @(posedge clk_i or posedge async_reset_i) begin
        if (async_reset_i) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[sync_depth_p-2:0], 1'b0};
        end
    end

    // The pin term makes assertion reach the outputs without waiting on the chain's flops.
    assign rst_seq_s = async_reset_i | sync_r[sync_depth_p-1];

    // Sequencer state and registered outputs, held in reset until the synchronizer drains.
    always_ff @(posedge clk_i or posedge rst_seq_s) begin
        if (rst_seq_s) begin
            state_r <= HOLD_S;
            cnt_r   <= '0;
            idx_r   <= '0;
            reset_r <= '1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
            idx_r   <= idx_n_s;
            reset_r <= reset_n_s;
            done_r  <= done_n_s;
        end
    end

    // Next-state logic: software reset overrides everything, otherwise hold/wait/done stepping.
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        idx_n_s   = idx_r;
        reset_n_s = reset_r;
        done_n_s  = done_r;
        if (ctrl.sw_reset_i) begin
            state_n_s = HOLD_S;
            cnt_n_s   = '0;
            idx_n_s   = '0;
            reset_n_s = '1;
            done_n_s  = 1'b0;
        end else begin
            case (state_r)
                HOLD_S: begin
                    if (cnt_r == cnt_last_lp) begin
                        reset_n_s[idx_r] = 1'b0;
                        cnt_n_s          = '0;
                        state_n_s        = WAIT_S;
                    end else begin
                        cnt_n_s = cnt_r + cnt_w_lp'(1);
                    end
                end
                WAIT_S: begin
                    if (ctrl.stage_ready_i[idx_r]) begin
                        if (idx_r == idx_last_lp) begin
                            state_n_s = DONE_S;
                            done_n_s  = 1'b1;
                        end else begin
                            idx_n_s   = idx_r + idx_w_lp'(1);
                            state_n_s = HOLD_S;
                        end
                    end else begin
                        state_n_s = WAIT_S;
                    end
                end
                DONE_S: begin
                    state_n_s = DONE_S;
                end
                default: begin
                    // Unreachable encoding: fall back to the fully reset condition.
                    state_n_s = HOLD_S;
                    cnt_n_s   = '0;
                    idx_n_s   = '0;
                    reset_n_s = '1;
                    done_n_s  = 1'b0;
                end
            endcase
        end
    end

    assign ctrl.reset_o = reset_r;
    assign ctrl.done_o  = done_r;
endmodule

// File: tb/tb_bsg_reset_release_sequencer.sv
// Directed scoreboard bench for bsg_reset_release_sequencer with 3 stages, 2 sync flops, hold of 4.
module tb_bsg_reset_release_sequencer;
    localparam int NS = 3;
    localparam int SD = 2;
    localparam int HC = 4;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic async_reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [3:0] sb_q[$];

    bsg_reset_release_sequencer_if #(.num_stages_p(NS)) bus ();

    bsg_reset_release_sequencer #(
        .num_stages_p (NS),
        .sync_depth_p (SD),
        .hold_cycles_p(HC)
    ) dut (
        .clk_i        (clk),
        .async_reset_i(async_reset),
        .ctrl         (bus)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Ready tied high, edge 1 = first edge after deassertion:
    // releases at 6, 11, 16; done from 17.
    function automatic logic [3:0] tied_exp(input int e);
        logic [2:0] r;
        r = (e < 6) ? 3'b111 : (e < 11) ? 3'b110 : (e < 16) ? 3'b100 : 3'b000;
        return {r, (e >= 17)};
    endfunction

    task automatic check(input string tag);
        logic [3:0] exp_v;
        logic [3:0] obs_v;
        obs_v = {bus.reset_o, bus.done_o};
        exp_v = sb_q.pop_front();
        vectors++;
        assert (obs_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed reset_o=%b done_o=%b expected reset_o=%b done_o=%b",
                   tag, obs_v[3:1], obs_v[0], exp_v[3:1], exp_v[0]);
        end
    endtask

    task automatic tick(input logic [3:0] exp_v, input string tag);
        sb_q.push_back(exp_v);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        bus.sw_reset_i    = 1'b0;
        bus.stage_ready_i = 3'b111;

        // Power-on pulse with the clock stopped.
        #3 async_reset = 1'b1;
        #1 sb_q.push_back({3'b111, 1'b0});
        check("por_no_clock");
        #2 async_reset = 1'b0;
        clk_en = 1'b1;

        // A: ready tied, ready dropped while DONE (ignored), then sw reset at edges 30-31.
        // After sw reset the last high sample is edge 31, so edge e behaves like tied edge e-29.
        for (int e = 1; e <= 42; e++) begin
            bus.stage_ready_i = (e >= 20 && e <= 27) ? 3'b000 : 3'b111;
            bus.sw_reset_i    = (e == 30 || e == 31);
            tick((e < 30) ? tied_exp(e) : tied_exp(e - 29), $sformatf("A_e%0d", e));
        end
        bus.sw_reset_i = 1'b0;

        // B: async reset while reset_o=100 aborts at once, then full sequence reruns.
        #2 async_reset = 1'b1;
        #1 sb_q.push_back({3'b111, 1'b0});
        check("B_abort");
        #1 async_reset = 1'b0;
        for (int e = 1; e <= 17; e++) begin
            tick(tied_exp(e), $sformatf("B_e%0d", e));
        end

        // D: async and sw together from DONE; async wins, sw low at release.
        #2 async_reset = 1'b1;
        bus.sw_reset_i = 1'b1;
        #1 sb_q.push_back({3'b111, 1'b0});
        check("D_abort");
        for (int e = 1; e <= 2; e++) begin
            tick({3'b111, 1'b0}, $sformatf("D_held%0d", e));
        end
        #2 async_reset = 1'b0;
        bus.sw_reset_i = 1'b0;
        for (int e = 1; e <= 17; e++) begin
            tick(tied_exp(e), $sformatf("D_e%0d", e));
        end

        // C: stage 0 ready held low through edge 20, first sampled high at edge 21.
        #2 async_reset = 1'b1;
        bus.stage_ready_i = 3'b110;
        #1 sb_q.push_back({3'b111, 1'b0});
        check("C_abort");
        #1 async_reset = 1'b0;
        for (int e = 1; e <= 31; e++) begin
            logic [2:0] r;
            bus.stage_ready_i = (e <= 20) ? 3'b110 : 3'b111;
            r = (e < 6) ? 3'b111 : (e < 25) ? 3'b110 : (e < 30) ? 3'b100 : 3'b000;
            tick({r, (e >= 31)}, $sformatf("C_e%0d", e));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
